// File: rtl/afifo_rd_pkg.sv
// rtl/afifo_rd_pkg.sv - shared types and pointer helper for the afifo read-side drain stage
package afifo_rd_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  // Buffer pointers wrap modulo BUF_DEPTH, which is not a power of two
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/afifo_rd_skid_buf.sv
// rtl/afifo_rd_skid_buf.sv - 3-entry FIFO-ordered register buffer with push/pop/occupancy
module afifo_rd_skid_buf
  import afifo_rd_pkg::*;
#(
  parameter int DataSize = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [DataSize-1:0] i_push_data,
  input  logic                i_pop,
  output logic [DataSize-1:0] o_head_data,
  output occ_t                o_occ
);

  logic [DataSize-1:0] r_mem [BUF_DEPTH];
  ptr_t                r_head;
  ptr_t                r_tail;
  occ_t                r_occ;
  logic                w_pop_ok;

  assign w_pop_ok    = i_pop && (r_occ != occ_t'(0));
  assign o_head_data = r_mem[r_head];
  assign o_occ       = r_occ;

  // Write at tail, retire at head; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop_ok) begin
        r_head <= ptr_inc(r_head);
      end
      case ({i_push, w_pop_ok})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The upstream Pop gating must never let a word arrive into a full buffer
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !w_pop_ok && (r_occ == occ_t'(BUF_DEPTH))));
`endif

endmodule

// File: rtl/afifo_rd_stream.sv
// rtl/afifo_rd_stream.sv - async FIFO read drain to valid/ready stream; stats enabled by AFIFO_RD_STATS_EN
module afifo_rd_stream
  import afifo_rd_pkg::*;
#(
  parameter int DataSize = 3,
  parameter int CntWidth = 16
) (
  input  logic                Rclk,
  input  logic                Rresetn,
  input  logic                empty,
  input  logic [DataSize-1:0] FifoData,
  output logic                Pop,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [DataSize-1:0] OutData,
  output logic [CntWidth-1:0] WordCount,
  output logic [CntWidth-1:0] StallCount
);

  logic       r_in_flight;
  occ_t       w_occ;
  logic [2:0] w_committed;
  logic       w_pop;
  logic       w_xfer;

  // Words already owned by this stage: buffered plus the one on its way from the FIFO
  assign w_committed = {1'b0, w_occ} + {2'b00, r_in_flight};
  assign w_pop       = Rresetn && !empty && (w_committed <= 3'd2);
  assign Pop         = w_pop;
  assign OutValid    = (w_occ != occ_t'(0));
  assign w_xfer      = OutValid && OutReady;

  // FIFO data lags Pop by one cycle; remember that a word is arriving
  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      r_in_flight <= 1'b0;
    end else begin
      r_in_flight <= w_pop;
    end
  end

  afifo_rd_skid_buf #(
    .DataSize(DataSize)
  ) u_buf (
    .i_clk       (Rclk),
    .i_rst_n     (Rresetn),
    .i_push      (r_in_flight),
    .i_push_data (FifoData),
    .i_pop       (w_xfer),
    .o_head_data (OutData),
    .o_occ       (w_occ)
  );

`ifdef AFIFO_RD_STATS_EN
  logic [CntWidth-1:0] r_word_cnt;
  logic [CntWidth-1:0] r_stall_cnt;

  // Saturating count of delivered words
  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      r_word_cnt <= '0;
    end else if (w_xfer && (r_word_cnt != '1)) begin
      r_word_cnt <= r_word_cnt + CntWidth'(1);
    end
  end

  // Saturating count of cycles the head word waited on downstream
  always_ff @(posedge Rclk or negedge Rresetn) begin
    if (!Rresetn) begin
      r_stall_cnt <= '0;
    end else if (OutValid && !OutReady && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CntWidth'(1);
    end
  end

  assign WordCount  = r_word_cnt;
  assign StallCount = r_stall_cnt;
`else
  assign WordCount  = '0;
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb/tb_afifo_rd_stream.sv - randomized scoreboard bench for afifo_rd_stream
module tb_afifo_rd_stream;

  localparam int DW = 3;
  localparam int CW = 16;
`ifdef AFIFO_RD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] fdata = '0;
  logic          rdy = 1'b0;
  logic          pop;
  logic          ovalid;
  logic [DW-1:0] odata;
  logic [CW-1:0] wc;
  logic [CW-1:0] sc;

  afifo_rd_stream #(.DataSize(DW), .CntWidth(CW)) dut (
    .Rclk       (clk),
    .Rresetn    (rst_n),
    .empty      (empty),
    .FifoData   (fdata),
    .Pop        (pop),
    .OutValid   (ovalid),
    .OutReady   (rdy),
    .OutData    (odata),
    .WordCount  (wc),
    .StallCount (sc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Upstream FIFO contents and the order words must come out in
  int src[$];
  int exp_q[$];

  int gen_pct = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  int pop_seen = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of the upstream FIFO model and stimulus; returns at posedge+1
  task automatic cycle();
    bit p;
    @(negedge clk);
    p = pop;
    if (p) pop_seen++;
    @(posedge clk);
    #1;
    if (p && src.size() > 0) fdata = DW'(src.pop_front());
    else fdata = DW'($urandom);
    if (gen_pct > 0 && int'($urandom_range(99)) < gen_pct && src.size() < 32) begin
      int w;
      w = int'($urandom_range(7));
      src.push_back(w);
      exp_q.push_back(w);
    end
    empty = (src.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    rdy   = int'($urandom_range(99)) < rdy_pct;
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs clear at once
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    src.delete();
    exp_q.delete();
    #1;
    check("rst_pop", pop, 0);
    check("rst_valid", ovalid, 0);
    check("rst_data", odata, 0);
    check("rst_wc", wc, 0);
    check("rst_sc", sc, 0);
    repeat (2) @(posedge clk);
    #1;
    empty = (src.size() == 0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    gen_pct = 0;
    gap_pct = 0;
    rdy_pct = 100;
    n = 0;
    while ((exp_q.size() > 0 || ovalid) && n < 200) begin
      cycle();
      n++;
    end
    check("drain_timeout", n >= 200, 0);
    repeat (3) cycle();
  endtask

  // Monitor: compares DUT behaviour with a word-counting reference each cycle
  int outst = 0;
  int prev_pop = 0;
  bit held_v = 1'b0;
  int held_d = 0;
  int m_word = 0;
  int m_stall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0;
      prev_pop = 0;
      held_v = 1'b0;
      m_word = 0;
      m_stall = 0;
    end else begin
      check("pop_rule", pop, (!empty && outst <= 2) ? 1 : 0);
      check("valid_rule", ovalid, ((outst - prev_pop) > 0) ? 1 : 0);
      if (held_v) check("data_hold", odata, held_d);
      if (ovalid && rdy) begin
        if (exp_q.size() == 0) check("unexpected_word", odata, -1);
        else check("out_data", odata, exp_q.pop_front());
      end
      check("word_count", wc, STATS ? m_word : 0);
      check("stall_count", sc, STATS ? m_stall : 0);
      if (ovalid && rdy) begin
        m_word++;
        outst--;
      end
      if (ovalid && !rdy) m_stall++;
      if (pop) outst++;
      check("overflow", outst > 3, 0);
      prev_pop = pop ? 1 : 0;
      held_v = ovalid && !rdy;
      held_d = int'(odata);
    end
  end

  initial begin
    // Reset then idle with empty high
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_valid", ovalid, 0);
    check("por_data", odata, 0);
    rst_n = 1'b1;
    gen_pct = 0;
    rdy_pct = 100;
    repeat (10) cycle();
    check("idle_pop", pop_seen, 0);
    check("idle_valid", ovalid, 0);
    check("idle_data", odata, 0);

    // Burst of four words with downstream ready
    repeat (5) cycle();
    for (int i = 1; i <= 4; i++) begin
      src.push_back(i);
      exp_q.push_back(i);
    end
    empty = 1'b0;
    drain();
    check("burst_wc", wc, STATS ? 4 : 0);

    // Stall with continuous supply: only three words may be pulled in
    do_reset();
    for (int i = 0; i < 8; i++) begin
      int w;
      w = int'($urandom_range(7));
      src.push_back(w);
      exp_q.push_back(w);
    end
    empty = 1'b0;
    rdy = 1'b0;
    rdy_pct = 0;
    pop_seen = 0;
    repeat (8) cycle();
    check("stall_pops", pop_seen, 3);
    check("stall_sc", sc, STATS ? 6 : 0);
    check("stall_valid", ovalid, 1);
    drain();
    check("stall_drained", src.size(), 0);

    // Reset while a word is in flight and two are buffered
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src.push_back(i);
      exp_q.push_back(i);
    end
    empty = 1'b0;
    rdy = 1'b0;
    rdy_pct = 0;
    pop_seen = 0;
    while (pop_seen < 3) cycle();
    do_reset();
    for (int i = 5; i <= 7; i++) begin
      src.push_back(i);
      exp_q.push_back(i);
    end
    empty = 1'b0;
    drain();
    check("post_rst_wc", wc, STATS ? 3 : 0);

    // Randomized traffic with occasional resets
    for (int blk = 0; blk < 10; blk++) begin
      gen_pct = int'($urandom_range(30, 100));
      gap_pct = int'($urandom_range(0, 30));
      rdy_pct = int'($urandom_range(20, 100));
      for (int c = 0; c < 200; c++) begin
        cycle();
        if ($urandom_range(299) == 0) do_reset();
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
